// File: rtl/mole_spawner.sv
// Mole sequencer for the whack-a-mole game: random gap, one visible mole, hit/miss arbitration
// and a saturating score. Everything the display and button logic see is registered.
module mole_spawner #(
    parameter int GAP_TICKS = 4,
    parameter int UP_TICKS  = 12,
    parameter int UP_MIN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [4:0] rnd,
    input  logic       hit_valid,
    input  logic [2:0] hit_hole,
    output logic [7:0] mole_mask,
    output logic       mole_active,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_UP   = 2'd2
    } state_t;

    localparam logic [7:0] GAP_BASE = 8'(GAP_TICKS);
    localparam logic [8:0] UP_LEN0  = 9'(UP_TICKS);
    localparam logic [8:0] UP_FLOOR = 9'(UP_MIN);

    // Never repeat the previous hole: a collision moves one hole to the right, wrapping 7 -> 0.
    function automatic logic [2:0] pick_hole(input logic [2:0] cand, input logic [2:0] last);
        logic [2:0] res;
        if (cand == last) begin
            res = last + 3'd1;
        end else begin
            res = cand;
        end
        return res;
    endfunction

    // Visible time shrinks by one tick per 8 points, never below the floor (no wrap on underflow).
    function automatic logic [7:0] calc_up_len(input logic [7:0] pts);
        logic [8:0] dec;
        logic [7:0] res;
        dec = {4'd0, pts[7:3]};
        if ((dec + UP_FLOOR) >= UP_LEN0) begin
            res = UP_FLOOR[7:0];
        end else begin
            res = 8'(UP_LEN0 - dec);
        end
        return res;
    endfunction

    state_t     state_r, state_next_s;
    logic [7:0] gap_cnt_r, gap_cnt_next_s;
    logic [7:0] up_cnt_r, up_cnt_next_s;
    logic [2:0] last_hole_r, last_hole_next_s;
    logic [7:0] mole_mask_r, mole_mask_next_s;
    logic       mole_active_r;
    logic       hit_pulse_r, hit_pulse_next_s;
    logic       miss_pulse_r, miss_pulse_next_s;
    logic [7:0] score_r, score_next_s;

    logic       hit_ok_s;
    logic       gap_done_s;
    logic       up_done_s;
    logic [2:0] new_hole_s;
    logic [7:0] new_gap_s;

    assign hit_ok_s   = hit_valid && (hit_hole == last_hole_r);
    assign gap_done_s = tick && (gap_cnt_r <= 8'd1);
    assign up_done_s  = tick && (up_cnt_r <= 8'd1);
    assign new_hole_s = pick_hole(rnd[2:0], last_hole_r);
    assign new_gap_s  = GAP_BASE + {6'd0, rnd[4:3]};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= 8'd0;
            up_cnt_r      <= 8'd0;
            last_hole_r   <= 3'd0;
            mole_mask_r   <= 8'd0;
            mole_active_r <= 1'b0;
            hit_pulse_r   <= 1'b0;
            miss_pulse_r  <= 1'b0;
            score_r       <= 8'd0;
        end else begin
            state_r       <= state_next_s;
            gap_cnt_r     <= gap_cnt_next_s;
            up_cnt_r      <= up_cnt_next_s;
            last_hole_r   <= last_hole_next_s;
            mole_mask_r   <= mole_mask_next_s;
            mole_active_r <= |mole_mask_next_s;
            hit_pulse_r   <= hit_pulse_next_s;
            miss_pulse_r  <= miss_pulse_next_s;
            score_r       <= score_next_s;
        end
    end

    // Next-state logic; a correct hit takes priority over an expiring tick.
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_GAP;
                ST_GAP: begin
                    if (gap_done_s) begin
                        state_next_s = ST_UP;
                    end else begin
                        state_next_s = ST_GAP;
                    end
                end
                ST_UP: begin
                    if (hit_ok_s || up_done_s) begin
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = ST_UP;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next values of counters and registered outputs.
    always_comb begin
        gap_cnt_next_s    = gap_cnt_r;
        up_cnt_next_s     = up_cnt_r;
        last_hole_next_s  = last_hole_r;
        mole_mask_next_s  = mole_mask_r;
        hit_pulse_next_s  = 1'b0;
        miss_pulse_next_s = 1'b0;
        score_next_s      = score_r;
        if (!enable) begin
            mole_mask_next_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    gap_cnt_next_s   = new_gap_s;
                    mole_mask_next_s = 8'd0;
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        gap_cnt_next_s   = 8'd0;
                        last_hole_next_s = new_hole_s;
                        mole_mask_next_s = 8'd1 << new_hole_s;
                        up_cnt_next_s    = calc_up_len(score_r);
                    end else if (tick) begin
                        gap_cnt_next_s = gap_cnt_r - 8'd1;
                    end else begin
                        gap_cnt_next_s = gap_cnt_r;
                    end
                end
                ST_UP: begin
                    if (hit_ok_s) begin
                        hit_pulse_next_s = 1'b1;
                        score_next_s     = (score_r == 8'hFF) ? 8'hFF : score_r + 8'd1;
                        mole_mask_next_s = 8'd0;
                        gap_cnt_next_s   = new_gap_s;
                        up_cnt_next_s    = 8'd0;
                    end else if (up_done_s) begin
                        miss_pulse_next_s = 1'b1;
                        mole_mask_next_s  = 8'd0;
                        gap_cnt_next_s    = new_gap_s;
                        up_cnt_next_s     = 8'd0;
                    end else if (tick) begin
                        up_cnt_next_s = up_cnt_r - 8'd1;
                    end else begin
                        up_cnt_next_s = up_cnt_r;
                    end
                end
                default: begin
                    mole_mask_next_s = 8'd0;
                end
            endcase
        end
    end

    assign mole_mask   = mole_mask_r;
    assign mole_active = mole_active_r;
    assign hit_pulse   = hit_pulse_r;
    assign miss_pulse  = miss_pulse_r;
    assign score       = score_r;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner: miss, hit, wrong hole, hole wrap,
// hit/expiry race, gap length, up-time clamp, score saturation, enable drop and reset.
module tb_mole_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [4:0] rnd;
    logic       hit_valid;
    logic [2:0] hit_hole;
    logic [7:0] mole_mask;
    logic       mole_active;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [7:0] score;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [2:0] m_last;
    int         m_score;

    mole_spawner dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick), .rnd(rnd),
        .hit_valid(hit_valid), .hit_hole(hit_hole), .mole_mask(mole_mask),
        .mole_active(mole_active), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic restart(input logic [4:0] r);
        rnd = r; reset = 1'b1; enable = 1'b0; tick = 1'b0; hit_valid = 1'b0; hit_hole = 3'd0;
        cyc();
        reset = 1'b0; enable = 1'b1;
        cyc();
        m_last = 3'd0; m_score = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tick = 1'b0; hit_valid = 1'b0; hit_hole = 3'd0; rnd = 5'd0;
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        n_checks++; if (mole_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", mole_mask); end
        n_checks++; if (mole_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", mole_active); end
        n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit_pulse); end
        n_checks++; if (miss_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b want 0", miss_pulse); end
        n_checks++; if (score !== 8'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
    endtask

    task automatic test_miss();
        restart(5'b00011);
        for (int i = 1; i <= 4; i++) begin
            ticks(1);
            if (i == 3) begin
                n_checks++; if (mole_mask !== 8'h00) begin n_fail++; $display("FAIL miss_early: got %h want 00", mole_mask); end
            end
            if (i < 4) repeat (3) cyc();
        end
        n_checks++; if (mole_mask !== 8'h08) begin n_fail++; $display("FAIL miss_up_mask: got %h want 08", mole_mask); end
        n_checks++; if (mole_active !== 1'b1) begin n_fail++; $display("FAIL miss_up_active: got %b want 1", mole_active); end
        for (int i = 1; i <= 12; i++) begin
            ticks(1);
            if (i == 11) begin
                n_checks++; if (mole_mask !== 8'h08 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_tick11: mask %h miss %b want 08 0", mole_mask, miss_pulse); end
            end
            if (i < 12) repeat (3) cyc();
        end
        n_checks++; if (miss_pulse !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: got %b want 1", miss_pulse); end
        n_checks++; if (mole_mask !== 8'h00 || mole_active !== 1'b0) begin n_fail++; $display("FAIL miss_clear: mask %h active %b want 00 0", mole_mask, mole_active); end
        n_checks++; if (score !== 8'd0 || hit_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_score: score %0d hit %b want 0 0", score, hit_pulse); end
        cyc();
        n_checks++; if (miss_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_width: got %b want 0", miss_pulse); end
    endtask

    task automatic test_hit();
        restart(5'b00011);
        ticks(4);
        n_checks++; if (mole_mask !== 8'h08) begin n_fail++; $display("FAIL hit_up: got %h want 08", mole_mask); end
        hit_valid = 1'b1; hit_hole = 3'd3;
        cyc();
        hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: hit %b miss %b want 1 0", hit_pulse, miss_pulse); end
        n_checks++; if (score !== 8'd1) begin n_fail++; $display("FAIL hit_score: got %0d want 1", score); end
        n_checks++; if (mole_mask !== 8'h00 || mole_active !== 1'b0) begin n_fail++; $display("FAIL hit_clear: mask %h active %b want 00 0", mole_mask, mole_active); end
        cyc();
        n_checks++; if (hit_pulse !== 1'b0 || score !== 8'd1) begin n_fail++; $display("FAIL hit_width: hit %b score %0d want 0 1", hit_pulse, score); end
    endtask

    task automatic test_wrong_hole();
        restart(5'b00011);
        hit_valid = 1'b1; hit_hole = 3'd0;
        cyc();
        hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b0 || score !== 8'd0) begin n_fail++; $display("FAIL gap_hit_ignored: hit %b score %0d want 0 0", hit_pulse, score); end
        ticks(4);
        n_checks++; if (mole_mask !== 8'h08) begin n_fail++; $display("FAIL wrong_up: got %h want 08", mole_mask); end
        ticks(5);
        hit_valid = 1'b1; hit_hole = 3'd5;
        cyc();
        hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b0 || mole_mask !== 8'h08) begin n_fail++; $display("FAIL wrong_ignored: hit %b mask %h want 0 08", hit_pulse, mole_mask); end
        ticks(6);
        n_checks++; if (mole_mask !== 8'h08 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL wrong_still_up: mask %h miss %b want 08 0", mole_mask, miss_pulse); end
        ticks(1);
        n_checks++; if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 8'd0) begin n_fail++; $display("FAIL wrong_expiry: miss %b hit %b score %0d want 1 0 0", miss_pulse, hit_pulse, score); end
    endtask

    task automatic test_wrap();
        restart(5'b00111);
        ticks(4);
        n_checks++; if (mole_mask !== 8'h80) begin n_fail++; $display("FAIL wrap_first: got %h want 80", mole_mask); end
        hit_valid = 1'b1; hit_hole = 3'd7;
        cyc();
        hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_hit7: got %b want 1", hit_pulse); end
        ticks(4);
        n_checks++; if (mole_mask !== 8'h01) begin n_fail++; $display("FAIL wrap_7_to_0: got %h want 01", mole_mask); end
        rnd = 5'b00010; hit_valid = 1'b1; hit_hole = 3'd0;
        cyc();
        hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b1 || score !== 8'd2) begin n_fail++; $display("FAIL wrap_hit0: hit %b score %0d want 1 2", hit_pulse, score); end
        ticks(4);
        n_checks++; if (mole_mask !== 8'h04) begin n_fail++; $display("FAIL wrap_hole2: got %h want 04", mole_mask); end
    endtask

    task automatic test_same_cycle();
        restart(5'b00011);
        ticks(4);
        ticks(11);
        n_checks++; if (mole_mask !== 8'h08 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL race_pre: mask %h miss %b want 08 0", mole_mask, miss_pulse); end
        tick = 1'b1; hit_valid = 1'b1; hit_hole = 3'd3; rnd = 5'b11001;
        cyc();
        tick = 1'b0; hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL race_hit_wins: hit %b miss %b want 1 0", hit_pulse, miss_pulse); end
        n_checks++; if (score !== 8'd1 || mole_mask !== 8'h00) begin n_fail++; $display("FAIL race_score: score %0d mask %h want 1 00", score, mole_mask); end
        cyc();
        n_checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL race_after: hit %b miss %b want 0 0", hit_pulse, miss_pulse); end
        ticks(6);
        n_checks++; if (mole_mask !== 8'h00) begin n_fail++; $display("FAIL gap7_early: got %h want 00", mole_mask); end
        ticks(1);
        n_checks++; if (mole_mask !== 8'h02) begin n_fail++; $display("FAIL gap7_up: got %h want 02", mole_mask); end
        rnd = 5'b00000; hit_valid = 1'b1; hit_hole = 3'd1;
        cyc();
        hit_valid = 1'b0;
        m_last = 3'd1; m_score = 2;
        n_checks++; if (hit_pulse !== 1'b1 || score !== 8'd2) begin n_fail++; $display("FAIL race_rehit: hit %b score %0d want 1 2", hit_pulse, score); end
    endtask

    task automatic spawn();
        logic [2:0] h;
        logic [7:0] want;
        h = m_last + 3'd3;
        want = 8'd1 << h;
        rnd = {2'b00, h};
        ticks(4);
        n_checks++; if (mole_mask !== want) begin n_fail++; $display("FAIL spawn_mask: got %h want %h", mole_mask, want); end
        m_last = h;
    endtask

    task automatic whack();
        hit_valid = 1'b1; hit_hole = m_last;
        cyc();
        hit_valid = 1'b0;
        if (m_score < 255) m_score++;
        n_checks++; if (hit_pulse !== 1'b1 || score !== 8'(m_score)) begin n_fail++; $display("FAIL whack: hit %b score %0d want 1 %0d", hit_pulse, score, m_score); end
    endtask

    task automatic check_up_len(input int len);
        spawn();
        ticks(len - 1);
        n_checks++; if (mole_mask === 8'h00 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL uplen_early: mask %h miss %b want up for %0d ticks", mole_mask, miss_pulse, len); end
        ticks(1);
        n_checks++; if (miss_pulse !== 1'b1 || score !== 8'(m_score)) begin n_fail++; $display("FAIL uplen_expiry: miss %b score %0d want 1 %0d", miss_pulse, score, m_score); end
    endtask

    task automatic test_saturation();
        while (m_score < 40) begin spawn(); whack(); end
        check_up_len(7);
        while (m_score < 64) begin spawn(); whack(); end
        check_up_len(4);
        while (m_score < 255) begin spawn(); whack(); end
        spawn();
        whack();
        n_checks++; if (score !== 8'd255) begin n_fail++; $display("FAIL sat_score: got %0d want 255", score); end
    endtask

    task automatic test_enable_reset();
        spawn();
        enable = 1'b0;
        cyc();
        n_checks++; if (mole_mask !== 8'h00 || mole_active !== 1'b0) begin n_fail++; $display("FAIL dis_clear: mask %h active %b want 00 0", mole_mask, mole_active); end
        n_checks++; if (score !== 8'd255 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL dis_hold: score %0d hit %b miss %b want 255 0 0", score, hit_pulse, miss_pulse); end
        tick = 1'b1; hit_valid = 1'b1; hit_hole = m_last;
        repeat (3) cyc();
        tick = 1'b0; hit_valid = 1'b0;
        n_checks++; if (hit_pulse !== 1'b0 || mole_mask !== 8'h00 || score !== 8'd255) begin n_fail++; $display("FAIL dis_ignore: hit %b mask %h score %0d want 0 00 255", hit_pulse, mole_mask, score); end
        enable = 1'b1;
        cyc();
        spawn();
        reset = 1'b1;
        cyc();
        n_checks++; if (mole_mask !== 8'h00 || mole_active !== 1'b0 || score !== 8'd0) begin n_fail++; $display("FAIL rst_up: mask %h active %b score %0d want 00 0 0", mole_mask, mole_active, score); end
        n_checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: hit %b miss %b want 0 0", hit_pulse, miss_pulse); end
        reset = 1'b0;
        cyc();
        n_checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || mole_mask !== 8'h00) begin n_fail++; $display("FAIL rst_after: hit %b miss %b mask %h want 0 0 00", hit_pulse, miss_pulse, mole_mask); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_wrong_hole();
        test_wrap();
        test_same_cycle();
        test_saturation();
        test_enable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
